lc3_datapath_p: RTL and testbench
=================================

LC3_DATAPATH_P -- requirements
Module: lc3_datapath_p

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data, address and register width (at least 16).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum cycles waited for Mem_Ack (at least 1).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LD_MAR/LD_MDR/LD_IR/LD_BEN/LD_CC/LD_REG/LD_PC/LD_LED  in  1 each  register load enables.
- GatePC/GateMDR/GateALU/GateMARMUX  in  1 each  bus drive selects.
- PCMUX, ADDR2MUX, ALUK  in  2 each  mux and ALU selects.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  in  1 each  mux selects.
- Mem_Rd_Start  in  1  one-cycle request to read M[MAR] into MDR.
- Mem_Ack  in  1  memory read data valid.
- Mem_Rdata  in  WIDTH  memory read data.
- Mem_Req  out  1  read request, held until ack or timeout.
- Mem_Addr  out  WIDTH  read address, latched from MAR at start.
- Mem_Busy  out  1  read in progress.
- Mem_Timeout  out  1  sticky timeout flag.
- Bus_Err  out  1  sticky bus-contention flag.
- MAR, MDR, IR, PC  out  WIDTH each  architectural registers.
- NZP  out  3  condition codes.
- BEN  out  1  branch enable.
- LED  out  12  LED register.

Function
REQ-004 BUS SHALL carry PC, MDR, ALU or MARMUX output when exactly one matching Gate is high; with none high, BUS SHALL be 0.
REQ-005 With more than one Gate high, BUS SHALL be 0 and Bus_Err SHALL set at the next edge and stay set until reset.
REQ-006 sext(IR[10:0]), sext(IR[8:0]), sext(IR[5:0]) and sext(IR[4:0]) SHALL be sign-extended to WIDTH.
REQ-007 The address adder SHALL compute (ADDR1MUX ? SR1 : PC) + ADDR2, modulo 2^WIDTH, where ADDR2MUX 00/01/10/11 selects 0/sext6/sext9/sext11.
REQ-008 PCMUX 00/01/10/11 SHALL select PC+1 (wrapping at 2^WIDTH-1 to 0)/BUS/adder/PC (hold); PC SHALL load on LD_PC.
REQ-009 ALUK 00/01/10/11 SHALL give A+B/A&B/~A/A, with A=SR1 and B = SR2MUX ? sext5 : SR2.
REQ-010 The register file SHALL hold 8 words of WIDTH bits, with these selects:
- DR = DRMUX ? 7 : IR[11:9].
- SR1 = SR1MUX ? IR[8:6] : IR[11:9].
- SR2 = IR[2:0].
REQ-011 Register reads SHALL be combinational; a write SHALL occur on LD_REG from BUS; a read of a register written in the same cycle SHALL return the old value.
REQ-012 On LD_CC, NZP SHALL load 100 if BUS[WIDTH-1]=1, 010 if BUS=0, else 001.
REQ-013 On LD_BEN, BEN SHALL load |(IR[11:9] & NZP), using the pre-edge NZP.
REQ-014 MAR and IR SHALL load BUS on their enables; LED SHALL load IR[11:0] on LD_LED.
REQ-015 The memory FSM SHALL have states IDLE and WAIT; Mem_Busy = Mem_Req = (state==WAIT).
REQ-016 In IDLE, Mem_Rd_Start SHALL, at the edge, latch MAR into Mem_Addr, clear the wait counter and enter WAIT.
REQ-017 In WAIT, Mem_Ack at an edge SHALL load MDR with Mem_Rdata and return to IDLE, giving a minimum of 2 edges from start to MDR valid.
REQ-018 In WAIT without ack, the counter SHALL increment; at MEM_TIMEOUT cycles, MDR SHALL load all-ones, Mem_Timeout SHALL set (sticky) and the FSM SHALL return to IDLE.
REQ-019 The following boundary cases SHALL behave as stated:
- Mem_Rd_Start while in WAIT is ignored.
- Mem_Ack while in IDLE is ignored.
- Ack on the timeout cycle: ack wins.
REQ-020 LD_MDR SHALL load BUS only in IDLE; while in WAIT, LD_MDR SHALL be ignored.
REQ-021 MAR changes during WAIT SHALL NOT alter Mem_Addr.

Reset
REQ-022 Reset low SHALL immediately and asynchronously set the following values:
- PC, MAR, MDR, IR, Mem_Addr, all 8 registers, LED = 0.
- NZP = 010.
- BEN, Bus_Err, Mem_Timeout = 0.
- FSM = IDLE, counter = 0.
REQ-023 Reset mid-read SHALL abort the read, dropping Mem_Req in the same cycle.

Structure
REQ-024 Package lc3_pkg SHALL hold the ALUK, PCMUX, ADDR2MUX and FSM-state enums and the NZP reset constant 3'b010.
REQ-025 The register file SHALL be a sub-module, lc3_regfile, parameterised by WIDTH.

Verification
REQ-026 Release reset with WIDTH=16 -> PC=0000, NZP=010, Mem_Busy=0, and all outputs 0 otherwise.
REQ-027 PC=FFFF, PCMUX=00, LD_PC -> PC=0000; GatePC+GateMDR both high -> BUS=0 and Bus_Err=1 until reset.
REQ-028 MAR=3000, pulse Mem_Rd_Start, Mem_Ack after 3 cycles with Rdata=1234 -> Mem_Addr=3000, MDR=1234, Busy low after the ack edge.
REQ-029 MEM_TIMEOUT=4 with no ack -> after 4 WAIT cycles MDR=FFFF, Mem_Timeout=1, FSM in IDLE.
REQ-030 R1=7FFF, R2=0001, IR=ADD R3,R1,R2, GateALU, LD_REG, LD_CC -> R3=8000, NZP=100; IR[11:9]=100 with LD_BEN -> BEN=1.
REQ-031 Reset asserted during WAIT -> Mem_Req=0 immediately; a later Mem_Ack is ignored.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 datapath slice.
//   aluk_e      : ALU operation select
//   pcmux_e     : next-PC source select
//   addr2mux_e  : address-adder offset select
//   mem_state_e : memory read sequencer states
//   NZP_RESET   : condition-code value after reset (zero)
package lc3_pkg;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_AND   = 2'b01,
      ALU_NOT   = 2'b10,
      ALU_PASSA = 2'b11
   } aluk_e;

   typedef enum logic [1:0] {
      PC_INC  = 2'b00,
      PC_BUS  = 2'b01,
      PC_ADDR = 2'b10,
      PC_HOLD = 2'b11
   } pcmux_e;

   typedef enum logic [1:0] {
      A2_ZERO   = 2'b00,
      A2_SEXT6  = 2'b01,
      A2_SEXT9  = 2'b10,
      A2_SEXT11 = 2'b11
   } addr2mux_e;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_e;

   localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/lc3_regfile.sv
// Eight-entry general register file.
//   Clk, Reset      : clock, async active-low reset (clears all entries)
//   we, dr, wdata   : synchronous write port
//   sr1, sr2        : combinational read selects
//   sr1_data/sr2_data : read data (pre-edge contents)
module lc3_regfile
   import lc3_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             we,
   input  logic [2:0]       dr,
   input  logic [2:0]       sr1,
   input  logic [2:0]       sr2,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] sr1_data,
   output logic [WIDTH-1:0] sr2_data
);

   logic [WIDTH-1:0] regs [8];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (we) begin
         regs[dr] <= wdata;
      end
   end

   assign sr1_data = regs[sr1];
   assign sr2_data = regs[sr2];

endmodule

// File: rtl/lc3_datapath_p.sv
// LC-3 datapath: shared bus, PC/MAR/MDR/IR/NZP/BEN/LED registers, ALU,
// address adder, register file and a timed memory-read sequencer.
//   Clk, Reset           : clock, async active-low reset
//   LD_*                 : register load enables
//   Gate*                : bus drivers (more than one => bus 0, Bus_Err)
//   PCMUX..ADDR1MUX      : mux / ALU selects
//   Mem_Rd_Start/Ack/Rdata : read handshake in
//   Mem_Req/Addr/Busy/Timeout : read handshake out
//   MAR, MDR, IR, PC, NZP, BEN, LED, Bus_Err : state outputs
//
// Memory sequencer
//   state    | meaning
//   MEM_IDLE | no read pending; LD_MDR may load from bus
//   MEM_WAIT | Mem_Req held, waiting for Mem_Ack or timeout
module lc3_datapath_p
   import lc3_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             LD_MAR,
   input  logic             LD_MDR,
   input  logic             LD_IR,
   input  logic             LD_BEN,
   input  logic             LD_CC,
   input  logic             LD_REG,
   input  logic             LD_PC,
   input  logic             LD_LED,
   input  logic             GatePC,
   input  logic             GateMDR,
   input  logic             GateALU,
   input  logic             GateMARMUX,
   input  logic [1:0]       PCMUX,
   input  logic [1:0]       ADDR2MUX,
   input  logic [1:0]       ALUK,
   input  logic             DRMUX,
   input  logic             SR1MUX,
   input  logic             SR2MUX,
   input  logic             ADDR1MUX,
   input  logic             Mem_Rd_Start,
   input  logic             Mem_Ack,
   input  logic [WIDTH-1:0] Mem_Rdata,
   output logic             Mem_Req,
   output logic [WIDTH-1:0] Mem_Addr,
   output logic             Mem_Busy,
   output logic             Mem_Timeout,
   output logic             Bus_Err,
   output logic [WIDTH-1:0] MAR,
   output logic [WIDTH-1:0] MDR,
   output logic [WIDTH-1:0] IR,
   output logic [WIDTH-1:0] PC,
   output logic [2:0]       NZP,
   output logic             BEN,
   output logic [11:0]      LED
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   mem_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic             rd_start, rd_ack, rd_tout;

   logic [WIDTH-1:0] bus, alu_out, addr_out, addr1, addr2, alu_b, pc_next;
   logic [WIDTH-1:0] sext5, sext6, sext9, sext11, sr1_data, sr2_data;
   logic [2:0]       dr_sel, sr1_sel;
   logic             bus_conflict;

   assign sext5  = {{(WIDTH-5){IR[4]}},   IR[4:0]};
   assign sext6  = {{(WIDTH-6){IR[5]}},   IR[5:0]};
   assign sext9  = {{(WIDTH-9){IR[8]}},   IR[8:0]};
   assign sext11 = {{(WIDTH-11){IR[10]}}, IR[10:0]};

   assign dr_sel  = DRMUX  ? 3'd7     : IR[11:9];
   assign sr1_sel = SR1MUX ? IR[8:6]  : IR[11:9];

   lc3_regfile #(.WIDTH(WIDTH)) u_regfile (
      .Clk      (Clk),
      .Reset    (Reset),
      .we       (LD_REG),
      .dr       (dr_sel),
      .sr1      (sr1_sel),
      .sr2      (IR[2:0]),
      .wdata    (bus),
      .sr1_data (sr1_data),
      .sr2_data (sr2_data)
   );

   always_comb begin
      addr1 = ADDR1MUX ? sr1_data : PC;
      case (addr2mux_e'(ADDR2MUX))
         A2_ZERO:   addr2 = '0;
         A2_SEXT6:  addr2 = sext6;
         A2_SEXT9:  addr2 = sext9;
         default:   addr2 = sext11;
      endcase
      addr_out = addr1 + addr2;
   end

   always_comb begin
      alu_b = SR2MUX ? sext5 : sr2_data;
      case (aluk_e'(ALUK))
         ALU_ADD:  alu_out = sr1_data + alu_b;
         ALU_AND:  alu_out = sr1_data & alu_b;
         ALU_NOT:  alu_out = ~sr1_data;
         default:  alu_out = sr1_data;
      endcase
   end

   // Any two drivers at once is a contention; the bus reads 0 in that case.
   assign bus_conflict = (GatePC  & GateMDR) | (GatePC  & GateALU) | (GatePC & GateMARMUX)
                       | (GateMDR & GateALU) | (GateMDR & GateMARMUX) | (GateALU & GateMARMUX);

   always_comb begin
      bus = '0;
      if (!bus_conflict) begin
         if (GatePC)          bus = PC;
         else if (GateMDR)    bus = MDR;
         else if (GateALU)    bus = alu_out;
         else if (GateMARMUX) bus = addr_out;
      end
   end

   always_comb begin
      case (pcmux_e'(PCMUX))
         PC_INC:  pc_next = PC + 1'b1;
         PC_BUS:  pc_next = bus;
         PC_ADDR: pc_next = addr_out;
         default: pc_next = PC;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state_q <= MEM_IDLE;
      else        state_q <= state_d;
   end

   // Ack is tested before the terminal count so it wins on the last cycle.
   always_comb begin
      state_d  = state_q;
      rd_start = 1'b0;
      rd_ack   = 1'b0;
      rd_tout  = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (Mem_Rd_Start) begin
               rd_start = 1'b1;
               state_d  = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (Mem_Ack) begin
               rd_ack  = 1'b1;
               state_d = MEM_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rd_tout = 1'b1;
               state_d = MEM_IDLE;
            end
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   assign Mem_Busy = (state_q == MEM_WAIT);
   assign Mem_Req  = (state_q == MEM_WAIT);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q       <= '0;
         Mem_Addr    <= '0;
         Mem_Timeout <= 1'b0;
         Bus_Err     <= 1'b0;
         PC          <= '0;
         MAR         <= '0;
         MDR         <= '0;
         IR          <= '0;
         NZP         <= NZP_RESET;
         BEN         <= 1'b0;
         LED         <= '0;
      end else begin
         if (rd_start) begin
            cnt_q    <= '0;
            Mem_Addr <= MAR;
         end else if (state_q == MEM_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (rd_tout)      Mem_Timeout <= 1'b1;
         if (bus_conflict) Bus_Err     <= 1'b1;

         if (rd_ack)                             MDR <= Mem_Rdata;
         else if (rd_tout)                       MDR <= '1;
         else if (LD_MDR && state_q == MEM_IDLE) MDR <= bus;

         if (LD_PC)  PC  <= pc_next;
         if (LD_MAR) MAR <= bus;
         if (LD_IR)  IR  <= bus;
         if (LD_LED) LED <= IR[11:0];
         if (LD_BEN) BEN <= |(IR[11:9] & NZP);
         if (LD_CC) begin
            if (bus[WIDTH-1])  NZP <= 3'b100;
            else if (bus == '0) NZP <= 3'b010;
            else               NZP <= 3'b001;
         end
      end
   end

endmodule

// File: tb/tb_lc3_datapath_p.sv
module tb_lc3_datapath_p;

   localparam int WIDTH = 16;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic             GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0]       PCMUX, ADDR2MUX, ALUK;
   logic             DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
   logic             Mem_Rd_Start, Mem_Ack;
   logic [WIDTH-1:0] Mem_Rdata;
   logic             Mem_Req, Mem_Busy, Mem_Timeout, Bus_Err, BEN;
   logic [WIDTH-1:0] Mem_Addr, MAR, MDR, IR, PC;
   logic [2:0]       NZP;
   logic [11:0]      LED;

   int n_cmp = 0;
   int n_err = 0;

   lc3_datapath_p #(.WIDTH(WIDTH), .MEM_TIMEOUT(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
      .Mem_Rd_Start(Mem_Rd_Start), .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata),
      .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Busy(Mem_Busy),
      .Mem_Timeout(Mem_Timeout), .Bus_Err(Bus_Err),
      .MAR(MAR), .MDR(MDR), .IR(IR), .PC(PC), .NZP(NZP), .BEN(BEN), .LED(LED)
   );

   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_ctl();
      LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0; LD_CC = 0; LD_REG = 0;
      LD_PC = 0; LD_LED = 0;
      GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
      PCMUX = 2'b11; ADDR2MUX = 0; ALUK = 0;
      DRMUX = 0; SR1MUX = 0; SR2MUX = 0; ADDR1MUX = 0;
      Mem_Rd_Start = 0; Mem_Ack = 0; Mem_Rdata = '0;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // One start edge, then ack on the following edge.
   task automatic load_mdr(input logic [WIDTH-1:0] v);
      Mem_Rd_Start = 1; step(); Mem_Rd_Start = 0;
      Mem_Ack = 1; Mem_Rdata = v; step();
      Mem_Ack = 0; Mem_Rdata = '0;
   endtask

   task automatic load_ir(input logic [WIDTH-1:0] v);
      load_mdr(v);
      GateMDR = 1; LD_IR = 1; step(); clear_ctl();
   endtask

   task automatic write_reg(input logic [WIDTH-1:0] ir_v, input logic [WIDTH-1:0] v);
      load_ir(ir_v);
      load_mdr(v);
      GateMDR = 1; LD_REG = 1; step(); clear_ctl();
   endtask

   initial begin
      clear_ctl();
      Reset = 0;
      step(); step();
      Reset = 1;
      step();

      check_val("rst_pc", PC, 16'h0000);
      check_val("rst_nzp", NZP, 3'b010);
      check_val("rst_busy", Mem_Busy, 0);
      check_val("rst_misc", {MAR, MDR, IR, Mem_Addr}, 0);
      check_val("rst_flags", {Mem_Req, Mem_Timeout, Bus_Err, BEN, LED}, 0);

      // PC load from bus, wrap, increment
      load_mdr(16'hFFFF);
      GateMDR = 1; PCMUX = 2'b01; LD_PC = 1; step(); clear_ctl();
      check_val("pc_bus", PC, 16'hFFFF);
      PCMUX = 2'b00; LD_PC = 1; step(); clear_ctl();
      check_val("pc_wrap", PC, 16'h0000);
      PCMUX = 2'b00; LD_PC = 1; step(); clear_ctl();
      check_val("pc_inc", PC, 16'h0001);
      PCMUX = 2'b11; LD_PC = 1; step(); clear_ctl();
      check_val("pc_hold", PC, 16'h0001);

      // Address adder with negative and positive offsets
      load_ir(16'h01FF);
      PCMUX = 2'b10; ADDR2MUX = 2'b10; LD_PC = 1; step(); clear_ctl();
      check_val("pc_addr_sext9", PC, 16'h0000);
      GateMARMUX = 1; ADDR2MUX = 2'b01; LD_MAR = 1; step(); clear_ctl();
      check_val("mar_sext6", MAR, 16'hFFFF);
      GateMARMUX = 1; ADDR2MUX = 2'b11; LD_MAR = 1; step(); clear_ctl();
      check_val("mar_sext11", MAR, 16'h01FF);
      LD_LED = 1; step(); clear_ctl();
      check_val("led", LED, 12'h1FF);

      // Read with ack after 3 cycles; MAR, LD_MDR, Rd_Start during WAIT have no effect
      load_mdr(16'h3000);
      GateMDR = 1; LD_MAR = 1; step(); clear_ctl();
      Mem_Rd_Start = 1; step(); clear_ctl();
      check_val("rd_busy", {Mem_Busy, Mem_Req}, 2'b11);
      check_val("rd_addr", Mem_Addr, 16'h3000);
      GatePC = 1; LD_MAR = 1; LD_MDR = 1; Mem_Rd_Start = 1; step(); clear_ctl();
      check_val("rd_mar_chg", MAR, 16'h0000);
      check_val("rd_addr_hold", Mem_Addr, 16'h3000);
      check_val("rd_ldmdr_ign", MDR, 16'h3000);
      step();
      Mem_Ack = 1; Mem_Rdata = 16'h1234; step(); clear_ctl();
      check_val("rd_data", MDR, 16'h1234);
      check_val("rd_done", Mem_Busy, 0);

      Mem_Ack = 1; Mem_Rdata = 16'h5555; step(); clear_ctl();
      check_val("idle_ack_ign", MDR, 16'h1234);
      check_val("idle_ack_busy", Mem_Busy, 0);

      // Timeout after 4 WAIT cycles
      Mem_Rd_Start = 1; step(); clear_ctl();
      step(); step(); step();
      check_val("to_still_wait", {Mem_Busy, Mem_Timeout}, 2'b10);
      step();
      check_val("to_mdr", MDR, 16'hFFFF);
      check_val("to_flag_idle", {Mem_Timeout, Mem_Busy}, 2'b10);

      // Ack on the timeout cycle wins
      Mem_Rd_Start = 1; step(); clear_ctl();
      step(); step(); step();
      Mem_Ack = 1; Mem_Rdata = 16'hABCD; step(); clear_ctl();
      check_val("ack_wins", MDR, 16'hABCD);
      check_val("ack_wins_idle", Mem_Busy, 0);

      // LD_MDR from bus in IDLE (adder = PC + sext11 = 0x01FF)
      GateMARMUX = 1; ADDR2MUX = 2'b11; LD_MDR = 1; step(); clear_ctl();
      check_val("ldmdr_idle", MDR, 16'h01FF);

      // Register file / ALU / condition codes
      write_reg(16'h0200, 16'h7FFF);   // R1
      write_reg(16'h0400, 16'h0001);   // R2
      load_ir(16'h1642);               // ADD R3,R1,R2
      GateALU = 1; SR1MUX = 1; ALUK = 2'b00; LD_REG = 1; LD_CC = 1; step(); clear_ctl();
      check_val("add_nzp", NZP, 3'b100);
      GateALU = 1; SR1MUX = 0; ALUK = 2'b11; LD_MAR = 1; step(); clear_ctl();
      check_val("add_r3", MAR, 16'h8000);
      GateALU = 1; SR1MUX = 0; ALUK = 2'b10; LD_MAR = 1; LD_CC = 1; step(); clear_ctl();
      check_val("not_r3", MAR, 16'h7FFF);
      check_val("not_nzp", NZP, 3'b001);
      GateALU = 1; SR1MUX = 1; SR2MUX = 1; ALUK = 2'b01; LD_MAR = 1; step(); clear_ctl();
      check_val("and_imm", MAR, 16'h0002);
      GateALU = 1; SR1MUX = 0; SR2MUX = 0; ALUK = 2'b01; LD_MAR = 1; LD_CC = 1; step(); clear_ctl();
      check_val("and_reg_zero", MAR, 16'h0000);
      check_val("zero_nzp", NZP, 3'b010);
      GateMARMUX = 1; ADDR1MUX = 1; SR1MUX = 1; ADDR2MUX = 2'b01; LD_MAR = 1; step(); clear_ctl();
      check_val("adder_sr1", MAR, 16'h8001);

      // BEN uses pre-edge NZP
      load_mdr(16'h0800);
      GateMDR = 1; LD_IR = 1; LD_CC = 1; step(); clear_ctl();
      LD_BEN = 1; step(); clear_ctl();
      check_val("ben_0", BEN, 0);
      load_mdr(16'hFFFF);
      GateMDR = 1; LD_CC = 1; step(); clear_ctl();
      load_mdr(16'h0001);
      GateMDR = 1; LD_CC = 1; LD_BEN = 1; step(); clear_ctl();
      check_val("ben_pre_edge", BEN, 1);
      check_val("ben_nzp_after", NZP, 3'b001);
      LD_BEN = 1; step(); clear_ctl();
      check_val("ben_clear", BEN, 0);

      // Bus contention
      GatePC = 1; GateMDR = 1; LD_MAR = 1; step(); clear_ctl();
      check_val("conflict_bus0", MAR, 16'h0000);
      check_val("conflict_err", Bus_Err, 1);
      step(); step();
      check_val("conflict_sticky", Bus_Err, 1);

      // Reset during WAIT
      Mem_Rd_Start = 1; step(); clear_ctl();
      check_val("rst_wait_busy", Mem_Req, 1);
      Reset = 0; #1;
      check_val("rst_async_req", Mem_Req, 0);
      check_val("rst_async_flags", {Bus_Err, Mem_Timeout}, 0);
      step();
      Reset = 1;
      Mem_Ack = 1; Mem_Rdata = 16'h9999; step(); clear_ctl();
      check_val("rst_late_ack_mdr", MDR, 16'h0000);
      check_val("rst_late_ack_busy", Mem_Busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
